// File: rtl/operand_fetch_pkg.sv
// Shared widths and handshake constants for the operand-fetch stage.
`ifndef OPERAND_FETCH_DEFINES
`define OPERAND_FETCH_DEFINES
`define BIT_DATA 8
`define OFF 1'b0
`define HS_VALID 1'b1
`define HS_IDLE 1'b0
`endif

package operand_fetch_pkg;

  localparam int DEF_BIT = `BIT_DATA;
  localparam int DEF_SZB = 4;
  localparam int DEF_TAG = 4;

endpackage

// File: rtl/operand_fetch_bypass.sv
// Per-operand forwarding: covers the file's registered-read blind spot and
// keeps the S1 capture and S2 hold values current with write-backs.
module operand_bypass
  import operand_fetch_pkg::*;
#(
  parameter int BIT = DEF_BIT,
  parameter int SZB = DEF_SZB
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [SZB-1:0] rf_addr_i,
  input  logic [SZB-1:0] s1_addr_i,
  input  logic [SZB-1:0] s2_addr_i,
  input  logic           wb_valid_i,
  input  logic [SZB-1:0] wb_addr_i,
  input  logic [BIT-1:0] wb_data_i,
  input  logic [BIT-1:0] rf_data_i,
  input  logic           xfer_i,
  input  logic           hold_i,
  input  logic [BIT-1:0] op_q_i,
  output logic [BIT-1:0] op_d_o
);

  logic           fwd_hit_q;
  logic [BIT-1:0] fwd_data_q;
  logic           fwd_hit_d;
  logic [BIT-1:0] eff_s;

  assign fwd_hit_d = wb_valid_i && (wb_addr_i == rf_addr_i);

  // Forward register: remembers a write the file did not see on this read.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fwd_hit_q  <= `OFF;
      fwd_data_q <= {BIT{1'b0}};
    end else begin
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= wb_data_i;
    end
  end

  // Operand next value: capture on transfer, patch while held, else keep.
  always_comb begin
    eff_s  = fwd_hit_q ? fwd_data_q : rf_data_i;
    op_d_o = op_q_i;
    if (xfer_i) begin
      if (wb_valid_i && (wb_addr_i == s1_addr_i)) begin
        op_d_o = wb_data_i;
      end else begin
        op_d_o = eff_s;
      end
    end else if (hold_i && wb_valid_i && (wb_addr_i == s2_addr_i)) begin
      op_d_o = wb_data_i;
    end else begin
      op_d_o = op_q_i;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Two-stage operand fetch in front of a 2R/1W registered register file:
// S1 waits on the read, S2 is the output register.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int BIT = `BIT_DATA,
  parameter int SZB = DEF_SZB,
  parameter int TAG = DEF_TAG
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [SZB-1:0] in_rs0,
  input  logic [SZB-1:0] in_rs1,
  input  logic [SZB-1:0] in_rd,
  input  logic [TAG-1:0] in_tag,
  output logic [SZB-1:0] rf_addr_rs0,
  output logic [SZB-1:0] rf_addr_rs1,
  input  logic [BIT-1:0] rf_rs0,
  input  logic [BIT-1:0] rf_rs1,
  output logic           rf_we,
  output logic [SZB-1:0] rf_addr_rd,
  output logic [BIT-1:0] rf_rd,
  input  logic           wb_valid,
  input  logic [SZB-1:0] wb_addr,
  input  logic [BIT-1:0] wb_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BIT-1:0] out_op0,
  output logic [BIT-1:0] out_op1,
  output logic [SZB-1:0] out_rd,
  output logic [TAG-1:0] out_tag
);

  logic           s1_valid_q, s1_valid_d;
  logic [SZB-1:0] s1_rs0_q, s1_rs1_q, s1_rd_q;
  logic [TAG-1:0] s1_tag_q;
  logic           out_valid_q, out_valid_d;
  logic [SZB-1:0] s2_rs0_q, s2_rs1_q, s2_rd_q;
  logic [TAG-1:0] s2_tag_q;
  logic [BIT-1:0] op0_q, op1_q, op0_d, op1_d;
  logic           s2_accept_s, issue_s, xfer_s, hold_s;

  assign s2_accept_s = !out_valid_q || out_ready;
  assign in_ready    = reset && (!s1_valid_q || s2_accept_s);
  assign issue_s     = in_valid && in_ready;
  assign xfer_s      = s1_valid_q && s2_accept_s;
  assign hold_s      = out_valid_q && !out_ready;

  assign rf_we      = reset && wb_valid;
  assign rf_addr_rd = wb_addr;
  assign rf_rd      = wb_data;

  assign out_valid = out_valid_q;
  assign out_op0   = op0_q;
  assign out_op1   = op1_q;
  assign out_rd    = s2_rd_q;
  assign out_tag   = s2_tag_q;

  // Read address mux: a stalled S1 keeps re-reading so its data stays fresh.
  always_comb begin
    rf_addr_rs0 = {SZB{1'b0}};
    rf_addr_rs1 = {SZB{1'b0}};
    if (issue_s) begin
      rf_addr_rs0 = in_rs0;
      rf_addr_rs1 = in_rs1;
    end else if (s1_valid_q) begin
      rf_addr_rs0 = s1_rs0_q;
      rf_addr_rs1 = s1_rs1_q;
    end else begin
      rf_addr_rs0 = {SZB{1'b0}};
      rf_addr_rs1 = {SZB{1'b0}};
    end
  end

  // Stage valid next-state.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (issue_s) begin
      s1_valid_d = `HS_VALID;
    end else if (xfer_s) begin
      s1_valid_d = `HS_IDLE;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (xfer_s) begin
      out_valid_d = `HS_VALID;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = `HS_IDLE;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  operand_bypass #(.BIT(BIT), .SZB(SZB)) u_bypass0 (
    .clock(clock), .reset(reset), .rf_addr_i(rf_addr_rs0), .s1_addr_i(s1_rs0_q),
    .s2_addr_i(s2_rs0_q), .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
    .wb_data_i(wb_data), .rf_data_i(rf_rs0), .xfer_i(xfer_s), .hold_i(hold_s),
    .op_q_i(op0_q), .op_d_o(op0_d)
  );

  operand_bypass #(.BIT(BIT), .SZB(SZB)) u_bypass1 (
    .clock(clock), .reset(reset), .rf_addr_i(rf_addr_rs1), .s1_addr_i(s1_rs1_q),
    .s2_addr_i(s2_rs1_q), .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
    .wb_data_i(wb_data), .rf_data_i(rf_rs1), .xfer_i(xfer_s), .hold_i(hold_s),
    .op_q_i(op1_q), .op_d_o(op1_d)
  );

  // Pipeline registers; reset drops any in-flight request.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid_q  <= `OFF;
      s1_rs0_q    <= {SZB{1'b0}};
      s1_rs1_q    <= {SZB{1'b0}};
      s1_rd_q     <= {SZB{1'b0}};
      s1_tag_q    <= {TAG{1'b0}};
      out_valid_q <= `OFF;
      s2_rs0_q    <= {SZB{1'b0}};
      s2_rs1_q    <= {SZB{1'b0}};
      s2_rd_q     <= {SZB{1'b0}};
      s2_tag_q    <= {TAG{1'b0}};
      op0_q       <= {BIT{1'b0}};
      op1_q       <= {BIT{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      op0_q       <= op0_d;
      op1_q       <= op1_d;
      if (issue_s) begin
        s1_rs0_q <= in_rs0;
        s1_rs1_q <= in_rs1;
        s1_rd_q  <= in_rd;
        s1_tag_q <= in_tag;
      end
      if (xfer_s) begin
        s2_rs0_q <= s1_rs0_q;
        s2_rs1_q <= s1_rs1_q;
        s2_rd_q  <= s1_rd_q;
        s2_tag_q <= s1_tag_q;
      end
    end
  end

endmodule
